// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the radix-2^K taint-tracked sequential multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Upper bound on taint vector width handled by prefix_or (product of WIDTH=1024).
    localparam int unsigned MaxTaintW = 2048;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Bit i of the result is the OR of bits 0..i: a taint reaches every bit a carry could.
    function automatic logic [MaxTaintW-1:0] prefix_or(input logic [MaxTaintW-1:0] v);
        logic [MaxTaintW-1:0] r;
        r[0] = v[0];
        for (int i = 1; i < MaxTaintW; i++) begin
            r[i] = r[i-1] | v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_tt_step.sv
// One radix-2^K iteration: partial product, its taint, and the accumulator/taint update.
module seq_mult_tt_step
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned K     = 2,
    parameter int unsigned CntW  = 2
) (
    input  logic [K-1:0]       mr_lo_i,
    input  logic [K-1:0]       mr_t_lo_i,
    input  logic [2*WIDTH-1:0] md_i,
    input  logic [2*WIDTH-1:0] md_t_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] acc_t_i,
    input  logic [CntW-1:0]    cnt_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] acc_t_o
);

    localparam int unsigned PW = 2 * WIDTH;

    if (PW > MaxTaintW) begin : g_bad_width
        $error("seq_mult_tt_step: 2*WIDTH exceeds MaxTaintW");
    end

    logic [PW-1:0] pp;
    logic [PW-1:0] pp_t;
    logic [PW-1:0] field;

    always_comb begin
        pp    = PW'(mr_lo_i) * md_i;
        // A tainted digit may take any value, so the whole K+WIDTH-bit partial product is suspect.
        field = ((PW'(1) << (K + WIDTH)) - PW'(1)) << (32'(cnt_i) * K);
        if (|mr_t_lo_i) begin
            pp_t = field;
        end else if (mr_lo_i != '0) begin
            pp_t = md_t_i;
        end else begin
            pp_t = '0;
        end
        acc_o   = acc_i + pp;
        acc_t_o = PW'(prefix_or(MaxTaintW'(acc_t_i | pp_t)));
    end

endmodule

// File: rtl/seq_mult_radix_tt.sv
// Fixed-latency radix-2^K shift-add multiplier with valid/ready handshake and taint shadow.
module seq_mult_radix_tt
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned K     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_valid_t,
    output logic               in_ready,
    output logic               in_ready_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplier_t,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplicand_t,
    output logic               out_valid,
    output logic               out_valid_t,
    input  logic               out_ready,
    input  logic               out_ready_t,
    output logic [2*WIDTH-1:0] product,
    output logic [2*WIDTH-1:0] product_t
);

    localparam int unsigned ITER = WIDTH / K;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = (clog2(ITER) > 0) ? clog2(ITER) : 1;

    if (K == 0 || WIDTH % K != 0) begin : g_bad_k
        $error("seq_mult_radix_tt: WIDTH must be a non-zero multiple of K");
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ctrl_t_q, ctrl_t_d;
    logic [WIDTH-1:0] mr_q, mr_d, mr_t_q, mr_t_d;
    logic [PW-1:0]   md_q, md_d, md_t_q, md_t_d;
    logic [PW-1:0]   acc_q, acc_d, acc_t_q, acc_t_d;
    logic [PW-1:0]   prod_q, prod_d, prod_t_q, prod_t_d;
    logic [PW-1:0]   step_acc, step_acc_t;

    seq_mult_tt_step #(
        .WIDTH(WIDTH),
        .K    (K),
        .CntW (CntW)
    ) u_step (
        .mr_lo_i  (mr_q[K-1:0]),
        .mr_t_lo_i(mr_t_q[K-1:0]),
        .md_i     (md_q),
        .md_t_i   (md_t_q),
        .acc_i    (acc_q),
        .acc_t_i  (acc_t_q),
        .cnt_i    (cnt_q),
        .acc_o    (step_acc),
        .acc_t_o  (step_acc_t)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_t_d = ctrl_t_q;
        mr_d     = mr_q;
        mr_t_d   = mr_t_q;
        md_d     = md_q;
        md_t_d   = md_t_q;
        acc_d    = acc_q;
        acc_t_d  = acc_t_q;
        prod_d   = prod_q;
        prod_t_d = prod_t_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mr_d     = multiplier;
                    mr_t_d   = multiplier_t;
                    md_d     = {{WIDTH{1'b0}}, multiplicand};
                    md_t_d   = {{WIDTH{1'b0}}, multiplicand_t};
                    acc_d    = '0;
                    acc_t_d  = '0;
                    cnt_d    = '0;
                    ctrl_t_d = in_valid_t;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d   = step_acc;
                acc_t_d = step_acc_t;
                md_d    = md_q << K;
                md_t_d  = md_t_q << K;
                mr_d    = mr_q >> K;
                mr_t_d  = mr_t_q >> K;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(ITER - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ctrl_t_d = ctrl_t_q | out_ready_t;
                // Snapshot the result so product stays put through IDLE and the next RUN.
                if (out_ready) begin
                    prod_d   = acc_q;
                    prod_t_d = acc_t_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ctrl_t_q <= 1'b0;
            mr_q     <= '0;
            mr_t_q   <= '0;
            md_q     <= '0;
            md_t_q   <= '0;
            acc_q    <= '0;
            acc_t_q  <= '0;
            prod_q   <= '0;
            prod_t_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_t_q <= ctrl_t_d;
            mr_q     <= mr_d;
            mr_t_q   <= mr_t_d;
            md_q     <= md_d;
            md_t_q   <= md_t_d;
            acc_q    <= acc_d;
            acc_t_q  <= acc_t_d;
            prod_q   <= prod_d;
            prod_t_q <= prod_t_d;
        end
    end

    always_comb begin
        in_ready    = (state_q == StIdle);
        in_ready_t  = ctrl_t_q;
        out_valid   = (state_q == StDone);
        out_valid_t = ctrl_t_q;
        product     = (state_q == StDone) ? acc_q : prod_q;
        product_t   = (state_q == StDone) ? acc_t_q : prod_t_q;
    end

endmodule

// File: tb/tb_seq_mult_radix_tt.sv
// Self-checking bench for seq_mult_radix_tt at WIDTH=8, K=2: vector table, random ops, corners.
module tb_seq_mult_radix_tt;

    logic        clk;
    logic        rst;
    logic        in_valid, in_valid_t, in_ready, in_ready_t;
    logic [7:0]  multiplier, multiplier_t, multiplicand, multiplicand_t;
    logic        out_valid, out_valid_t, out_ready, out_ready_t;
    logic [15:0] product, product_t;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_mult_radix_tt #(
        .WIDTH(8),
        .K    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_valid_t    (in_valid_t),
        .in_ready      (in_ready),
        .in_ready_t    (in_ready_t),
        .multiplier    (multiplier),
        .multiplier_t  (multiplier_t),
        .multiplicand  (multiplicand),
        .multiplicand_t(multiplicand_t),
        .out_valid     (out_valid),
        .out_valid_t   (out_valid_t),
        .out_ready     (out_ready),
        .out_ready_t   (out_ready_t),
        .product       (product),
        .product_t     (product_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] a, b, at, bt;
        int         hold;
        logic [15:0] ep, ept;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Union of all partial-product taints, then everything from its lowest set bit upward.
    function automatic logic [15:0] model_taint(input logic [7:0] a, input logic [7:0] at,
                                                input logic [7:0] bt);
        logic [15:0] u;
        logic [15:0] r;
        u = '0;
        for (int i = 0; i < 4; i++) begin
            if (((at >> (2 * i)) & 8'h3) != 0) u = u | (16'h03FF << (2 * i));
            else if (((a >> (2 * i)) & 8'h3) != 0) u = u | ({8'h00, bt} << (2 * i));
        end
        r = '0;
        for (int j = 15; j >= 0; j--) begin
            if (u[j]) r = 16'hFFFF << j;
        end
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] at, input logic [7:0] bt, input logic ivt,
                          input int hold, input logic [15:0] ep, input logic [15:0] ept);
        int cyc;
        check({tag, " idle_in_ready"}, 32'(in_ready), 32'd1);
        in_valid       = 1'b1;
        in_valid_t     = ivt;
        multiplier     = a;
        multiplicand   = b;
        multiplier_t   = at;
        multiplicand_t = bt;
        out_ready      = (hold == 0);
        tick();
        in_valid       = 1'b0;
        in_valid_t     = 1'b0;
        multiplier     = 8'($urandom);
        multiplicand   = 8'($urandom);
        multiplier_t   = 8'($urandom);
        multiplicand_t = 8'($urandom);
        check({tag, " run_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " run_in_ready_t"}, 32'(in_ready_t), 32'(ivt));
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd4);
        check({tag, " product"}, 32'(product), 32'(ep));
        check({tag, " product_t"}, 32'(product_t), 32'(ept));
        check({tag, " out_valid_t"}, 32'(out_valid_t), 32'(ivt));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            tick();
            check({tag, " hold_out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " hold_product"}, 32'(product), 32'(ep));
        end
        out_ready = 1'b1;
        tick();
        check({tag, " pop_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " pop_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle_product"}, 32'(product), 32'(ep));
        check({tag, " idle_product_t"}, 32'(product_t), 32'(ept));
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        int seen;
        logic [7:0] ra, rb, rat, rbt;

        vecs[0] = '{"plain",     8'd11,  8'd13,  8'h00, 8'h00, 0, 16'd143,  16'h0000};
        vecs[1] = '{"md_t_lsb",  8'd11,  8'd13,  8'h00, 8'h01, 0, 16'd143,  16'hFFFF};
        vecs[2] = '{"zero_a",    8'h00,  8'hFF,  8'h00, 8'hFF, 0, 16'h0000, 16'h0000};
        vecs[3] = '{"mr_t_msb",  8'h80,  8'h01,  8'h80, 8'h00, 0, 16'h0080, 16'hFFC0};
        vecs[4] = '{"max_hold",  8'hFF,  8'hFF,  8'h00, 8'h00, 5, 16'hFE01, 16'h0000};
        vecs[5] = '{"md_t_msb",  8'h01,  8'h80,  8'h00, 8'h80, 0, 16'h0080, 16'hFF80};
        vecs[6] = '{"mr_t_dig1", 8'h04,  8'h03,  8'h04, 8'h00, 2, 16'h000C, 16'hFFFC};

        rst = 1'b1;
        in_valid = 1'b0; in_valid_t = 1'b0;
        multiplier = '0; multiplier_t = '0; multiplicand = '0; multiplicand_t = '0;
        out_ready = 1'b0; out_ready_t = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst product", 32'(product), 32'd0);
        check("rst product_t", 32'(product_t), 32'd0);
        check("rst in_ready_t", 32'(in_ready_t), 32'd0);
        check("rst out_valid_t", 32'(out_valid_t), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].at, vecs[i].bt, 1'b0,
                   vecs[i].hold, vecs[i].ep, vecs[i].ept);
        end

        // Control taint sticks through IDLE until an untainted accept.
        run_op("ctrl_taint", 8'd7, 8'd9, 8'h00, 8'h00, 1'b1, 1, 16'd63, 16'h0000);
        check("ctrl_taint idle_in_ready_t", 32'(in_ready_t), 32'd1);
        run_op("ctrl_clear", 8'd5, 8'd6, 8'h00, 8'h00, 1'b0, 0, 16'd30, 16'h0000);

        for (int i = 0; i < 30; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rat = 8'($urandom & $urandom & $urandom);
            rbt = 8'($urandom & $urandom & $urandom);
            if (i % 3 == 0) begin
                rat = '0;
                rbt = '0;
            end
            run_op($sformatf("rand%0d", i), ra, rb, rat, rbt, 1'b0,
                   int'($urandom_range(0, 3)), 16'(ra) * 16'(rb), model_taint(ra, rat, rbt));
        end

        // Reset in the middle of RUN discards the operation and the tainted control.
        in_valid = 1'b1; in_valid_t = 1'b1;
        multiplier = 8'hFF; multiplicand = 8'hFF;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_valid_t = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun in_ready", 32'(in_ready), 32'd1);
        check("midrun out_valid", 32'(out_valid), 32'd0);
        check("midrun in_ready_t", 32'(in_ready_t), 32'd0);
        check("midrun product", 32'(product), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrun no_out_valid", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
